// File: rtl/dd_cdc_pkg.sv
// Shared FSM type and constants for the dd_cdc toggle-handshake transmitter/receiver pair.
package dd_cdc_pkg;

    typedef enum logic [1:0] {INIT, IDLE, WAIT_ACK} dd_cdc_hs_st_t;

    localparam int unsigned DD_CDC_MIN_STAGES = 2;

endpackage

// File: rtl/dd_sync.sv
// Multi-flop synchronizer for signals crossing into the clk_i domain; resets to all-zero.
module dd_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int unsigned i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/dd_cdc_hs_tx.sv
// Source side of a two-phase req/ack CDC handshake: accepts a word, toggles req, waits for ack.
// Optional sticky ack timeout flag enabled by defining DD_CDC_HS_TX_TIMEOUT_EN.
module dd_cdc_hs_tx
    import dd_cdc_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned STAGES    = 2,
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             cdc_req_o,
    output logic [WIDTH-1:0] cdc_data_o,
    input  logic             cdc_ack_i,
    output logic             err_timeout_o
);

    localparam int unsigned SyncStages = (STAGES < DD_CDC_MIN_STAGES) ? DD_CDC_MIN_STAGES : STAGES;
    localparam int unsigned SettleW    = $clog2(SyncStages + 1);

    logic ack_sync;

    dd_sync #(
        .WIDTH (1),
        .STAGES(SyncStages)
    ) u_ack_sync (
        .clk_i (clk),
        .rst_ni(rst_n),
        .d_i   (cdc_ack_i),
        .q_o   (ack_sync)
    );

    dd_cdc_hs_st_t    state_q, state_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ready_q;
    logic [SettleW-1:0] settle_q, settle_d;
    logic             settled;
    logic             accept;

    // The synchronizer resets to 0, so INIT must not trust ack_sync until the chain has
    // refilled with the live ack level; otherwise a held stale ack would be missed.
    assign settled = (settle_q == SettleW'(SyncStages));

    always_comb begin
        settle_d = settle_q;
        if (!settled) begin
            settle_d = settle_q + SettleW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        accept  = 1'b0;
        case (state_q)
            INIT: begin
                if (settled && (ack_sync == req_q)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (valid_i) begin
                    accept  = 1'b1;
                    data_d  = data_i;
                    req_d   = ~req_q;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_sync == req_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INIT;
            req_q    <= 1'b0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            data_q   <= data_d;
            ready_q  <= (state_d == IDLE);
            settle_q <= settle_d;
        end
    end

    assign ready_o    = ready_q;
    assign cdc_req_o  = req_q;
    assign cdc_data_o = data_q;

`ifdef DD_CDC_HS_TX_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (accept) begin
            cnt_d = '0;
        end else if ((state_q == WAIT_ACK) && (cnt_q != '1)) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
        // Flag only; the FSM keeps waiting so a late ack still completes the transfer.
        if ((state_q == WAIT_ACK) && (cnt_d == '1)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_timeout_o = err_q;
`else
    localparam bit TimeoutWValid = (TIMEOUT_W != 0);

    assign err_timeout_o = 1'b0 & TimeoutWValid;
`endif

endmodule
